// File: rtl/mem_unit.sv
// Byte-wide single-port synchronous RAM for the 6502 bus: registered read-first
// port, plus a whole-array bulk-load and a continuous monitor for test benches.
module mem_unit #(
   parameter int DEPTH      = 4096,
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [WIDTH-1:0]         din,
   input  logic [ADDR_WIDTH-1:0]    addr,
   output logic [WIDTH-1:0]         dout,
   input  logic                     override_mem,
   input  logic [DEPTH*WIDTH-1:0]   mem_override_in,
   output logic [DEPTH*WIDTH-1:0]   mem_monitor
);

   localparam int IDX_W = $clog2(DEPTH);

   // Array kept as one flat vector so the bulk-load and monitor are direct copies.
   logic [DEPTH*WIDTH-1:0] mem_q;
   logic [IDX_W-1:0]       idx;

   assign idx = addr[IDX_W-1:0];

   // High address bits alias onto the array and are deliberately dropped.
   generate
      if (ADDR_WIDTH > IDX_W) begin : g_alias
         logic unused_high;
         assign unused_high = ^addr[ADDR_WIDTH-1:IDX_W];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (override_mem) begin
         mem_q <= mem_override_in;
      end else if (!reset && we) begin
         mem_q[int'(idx)*WIDTH +: WIDTH] <= din;
      end

      // Read-first: sees the array as it was before this edge's update.
      if (reset) begin
         dout <= '0;
      end else begin
         dout <= mem_q[int'(idx)*WIDTH +: WIDTH];
      end
   end

   assign mem_monitor = mem_q;

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit: a byte-array model of the RAM checked against dout
// and mem_monitor every cycle, plus literal checks at the scenario points.
module tb_mem_unit;

   localparam int DEPTH = 4096;
   localparam int W     = 8;
   localparam int AW    = 16;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 we = 1'b0;
   logic [W-1:0]         din = '0;
   logic [AW-1:0]        addr = '0;
   logic [W-1:0]         dout;
   logic                 override_mem = 1'b0;
   logic [DEPTH*W-1:0]   img = '0;
   logic [DEPTH*W-1:0]   mem_monitor;

   int n_checks = 0;
   int n_fails  = 0;

   mem_unit #(.DEPTH(DEPTH), .WIDTH(W), .ADDR_WIDTH(AW)) dut (
      .clk(clk),
      .reset(reset),
      .we(we),
      .din(din),
      .addr(addr),
      .dout(dout),
      .override_mem(override_mem),
      .mem_override_in(img),
      .mem_monitor(mem_monitor)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- model ----------------
   logic [W-1:0] model_mem [DEPTH];
   bit           mem_known = 1'b0;
   logic [W-1:0] exp_dout = '0;
   bit           dout_known = 1'b0;

   always @(posedge clk) begin
      int a;
      a = int'(addr) % DEPTH;
      if (reset) begin
         exp_dout   = '0;
         dout_known = 1'b1;
      end else begin
         exp_dout   = model_mem[a];
         dout_known = mem_known;
      end
      if (override_mem) begin
         for (int i = 0; i < DEPTH; i++) model_mem[i] = img[i*W +: W];
         mem_known = 1'b1;
      end else if (!reset && we) begin
         model_mem[a] = din;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (dout_known) begin
         n_checks++;
         if (dout !== exp_dout) begin
            n_fails++;
            $display("FAIL cyc_dout: dout=%02h expected=%02h at %0t", dout, exp_dout, $time);
         end
      end
      if (mem_known) begin
         int bad;
         bad = -1;
         for (int i = 0; i < DEPTH; i++)
            if (bad < 0 && mem_monitor[i*W +: W] !== model_mem[i]) bad = i;
         n_checks++;
         if (bad >= 0) begin
            n_fails++;
            $display("FAIL cyc_monitor: byte %03h=%02h expected=%02h at %0t",
                     bad, mem_monitor[bad*W +: W], model_mem[bad], $time);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
      we = 1'b1; addr = a; din = d;
      tick();
      we = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a);
      we = 1'b0; addr = a;
      tick();
   endtask

   function automatic logic [W-1:0] mon(input int i);
      return mem_monitor[i*W +: W];
   endfunction

   // Directed back-to-back write vectors: address, data.
   logic [AW-1:0] vec_a [8] = '{16'h0200, 16'h0201, 16'h0FFE, 16'h3201,
                                16'h0000, 16'h8FFF, 16'h0202, 16'h0300};
   logic [W-1:0]  vec_d [8] = '{8'h01, 8'h02, 8'h03, 8'h04,
                                8'hC3, 8'h5A, 8'h07, 8'h08};

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < DEPTH; i++) img[i*W +: W] = i[7:0];

      // Override during reset: image byte i = i[7:0]
      reset = 1'b1; override_mem = 1'b1;
      tick();
      override_mem = 1'b0;
      check8("ovr_rst_dout", dout, 8'h00);
      check8("ovr_rst_b0ff", mon(16'h0FF), 8'hFF);
      check8("ovr_rst_bfff", mon(16'hFFF), 8'hFF);
      check8("ovr_rst_b123", mon(16'h123), 8'h23);

      // Writes are blocked while in reset
      we = 1'b1; addr = 16'h0010; din = 8'hAA;
      for (int c = 0; c < 3; c++) begin
         tick();
         check8("rst_dout", dout, 8'h00);
         check8("rst_b010", mon(16'h010), 8'h10);
      end
      we = 1'b0; reset = 1'b0;

      rd(16'h0000); check8("rd_0000", dout, 8'h00);
      rd(16'h00FF); check8("rd_00ff", dout, 8'hFF);
      rd(16'h0FFF); check8("rd_0fff", dout, 8'hFF);

      // Write then read
      wr(16'h0123, 8'h5C);
      check8("wr_mon_123", mon(16'h123), 8'h5C);
      rd(16'h0123); check8("rd_0123", dout, 8'h5C);

      // Read-first collision
      wr(16'h0040, 8'h11);
      wr(16'h0040, 8'h22);
      check8("coll_old", dout, 8'h11);
      rd(16'h0040); check8("coll_new", dout, 8'h22);

      // Override beats write
      img[16'h20*W +: W] = 8'h77;
      override_mem = 1'b1; we = 1'b1; addr = 16'h0020; din = 8'h99;
      tick();
      override_mem = 1'b0; we = 1'b0;
      check8("ovr_beats_wr", mon(16'h020), 8'h77);
      check8("ovr_clears_123", mon(16'h123), 8'h23);

      // Holding override reloads each cycle
      override_mem = 1'b1;
      tick();
      img[16'h30*W +: W] = 8'hE7;
      tick();
      override_mem = 1'b0;
      check8("ovr_hold", mon(16'h030), 8'hE7);

      // Aliasing
      wr(16'hF005, 8'hE1);
      check8("alias_mon", mon(16'h005), 8'hE1);
      rd(16'h0005); check8("alias_rd", dout, 8'hE1);

      // Back-to-back writes, then read back
      for (int i = 0; i < 8; i++) begin
         we = 1'b1; addr = vec_a[i]; din = vec_d[i];
         tick();
      end
      we = 1'b0;
      check8("b2b_mon_ffe", mon(16'hFFE), 8'h03);
      check8("b2b_mon_201", mon(16'h201), 8'h04);
      check8("b2b_mon_fff", mon(16'hFFF), 8'h5A);
      for (int i = 0; i < 8; i++) rd(vec_a[i]);
      check8("b2b_last_rd", dout, 8'h08);

      // Reset mid-run zeroes dout but preserves contents
      reset = 1'b1; addr = 16'h0000;
      tick();
      check8("rst2_dout", dout, 8'h00);
      check8("rst2_keep", mon(16'h000), 8'hC3);
      reset = 1'b0;
      rd(16'h0000); check8("rst2_rd", dout, 8'hC3);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
